product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream consumer of the `multiply` stage. It accepts a stream of WIDTH-bit unsigned products over a valid/ready handshake and sums each block of COUNT products into an ACC_WIDTH-bit accumulator. It presents each block result, with a sticky overflow flag, on a valid/ready output port. The block holds the result until the consumer accepts it.

## Interface

**Parameters**
- `WIDTH`, 16: product width; matches the `multiply` output width.
- `COUNT`, 8: number of products per block; must be ≥ 1.
- `ACC_WIDTH`, 24: accumulator and result width; must be ≥ WIDTH.

**Ports**
- `clk`  in  1  single clock; all logic is rising-edge.
- `nReset`  in  1  synchronous, active-high reset (asserted = 1).
- `product`  in  WIDTH  unsigned product, driven from `multiply.multply`.
- `in_valid`  in  1  `product` is valid this cycle.
- `in_ready`  out  1  block can accept `product` this cycle.
- `clear`  in  1  synchronous abort of the block in progress.
- `sum`  out  ACC_WIDTH  block result.
- `sum_valid`  out  1  `sum` and `overflow` are valid.
- `sum_ready`  in  1  consumer accepts the result.
- `overflow`  out  1  a carry out of ACC_WIDTH occurred during the block.

## Operation

- **Accept rule:** a product is accepted on a cycle where `in_valid & in_ready`.
- **States:** ACCUM and HOLD. Reset enters ACCUM.
- **ACCUM:**
  - `in_ready` = 1.
  - On accept: `acc <= acc + product` (modulo 2^ACC_WIDTH) and `cnt <= cnt + 1`.
  - On accept, the internal overflow flag `ovf` is set if the addition carries out of ACC_WIDTH.
  - On the COUNT-th accept (`cnt == COUNT-1`): `sum <= acc + product`, `overflow <= ovf | carry`, `sum_valid <= 1`. In the same cycle `acc`, `cnt` and `ovf` clear to 0 and the state moves to HOLD.
- **HOLD:**
  - `in_ready` = 0; `in_valid` is ignored.
  - `sum` and `overflow` are held stable.
  - When `sum_ready` = 1: `sum_valid <= 0` and the state moves to ACCUM.
- **`clear`:**
  - In ACCUM, `clear` sets `acc`, `cnt` and `ovf` to 0. `clear` has priority: a product offered in the same cycle is discarded.
  - In HOLD, `clear` has no effect on the held result.
- **After the output handshake:** `sum` and `overflow` keep their last values; only `sum_valid` drops.
- **Arithmetic:** all values are unsigned. `product` is zero-extended to ACC_WIDTH. No saturation; wrap-around is reported through `overflow`.
- **Gaps:** gaps in `in_valid` are allowed and do not affect `cnt`.

## Timing

- **Reset:** while `nReset` = 1, at each rising edge:
  - state = ACCUM;
  - `acc`, `cnt`, `ovf` = 0;
  - `sum` = 0, `sum_valid` = 0, `overflow` = 0;
  - `in_ready` = 0 (gated by `nReset`).
- **After reset:** `in_ready` = 1 in the first cycle with `nReset` = 0.
- **Reset mid-operation:** reset mid-block discards the partial sum. Reset during HOLD drops `sum_valid` and the result is lost.
- **Latency:** `sum_valid` rises at the edge that accepts the COUNT-th product, i.e. it is visible the cycle after the final accept.
- **Output handshake:** the result transfers on the cycle with `sum_valid & sum_ready`. `in_ready` returns to 1 in the next cycle.
- **Throughput:** minimum COUNT + 1 cycles per block when `in_valid` and `sum_ready` are held at 1.
- **`in_ready`** is a function of state and `nReset` only; it has no combinational path from `in_valid` or `sum_ready`.
- **`COUNT` = 1:** every accepted product goes straight to HOLD.

## Test plan

1. **Reset:** hold `nReset` = 1 for 5 cycles with `in_valid` = 1 → `sum` = 0, `sum_valid` = 0, `overflow` = 0 and `in_ready` = 0 throughout; `in_ready` = 1 in the first cycle after release.
2. **Basic block** (WIDTH=16, COUNT=4, ACC_WIDTH=20): with `sum_ready` = 1, products 0x0025, 0x004A, 0x006F, 0x0094 on consecutive cycles → `sum` = 0x00172, `overflow` = 0. `sum_valid` is high for exactly one cycle, the cycle after the 4th accept. `in_ready` is 0 during that cycle.
3. **Backpressure:** complete a block, then hold `sum_ready` = 0 for 10 cycles while `in_valid` = 1 → `sum`, `overflow` and `sum_valid` = 1 are stable and `in_ready` = 0 throughout. Release `sum_ready` → `sum_valid` = 0 and `in_ready` = 1 the next cycle; no products are counted during HOLD.
4. **Overflow** (ACC_WIDTH=17, COUNT=4): products 0xFFFF ×4 → `sum` = 0x1FFFC, `overflow` = 1. The next block of four 0x0000 → `sum` = 0, `overflow` = 0.
5. **`clear`:** accept 0x0010 and 0x0020, then assert `clear` together with `in_valid` (product 0x0030). Then feed 0x0001 ×4 → `sum` = 0x00004; the 0x0030 product was discarded. `clear` asserted during HOLD leaves the held `sum` unchanged.
6. **Reset mid-operation:** accept 3 products, pulse `nReset` for 1 cycle, then feed 0x0002 ×4 → `sum` = 0x00008. Reset asserted during HOLD → `sum_valid` = 0 and `sum` = 0 on the next cycle.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the product source, the accumulator and the
// result consumer. The accumulator sits on the slave side; the environment
// (upstream multiply stage plus downstream consumer) sits on the master side.
interface product_accumulator_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
);

  logic [WIDTH-1:0]     product;
  logic                 in_valid;
  logic                 in_ready;
  logic                 clear;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sum_valid;
  logic                 sum_ready;
  logic                 overflow;

  modport master (
    output product, in_valid, clear, sum_ready,
    input  in_ready, sum, sum_valid, overflow
  );

  modport slave (
    input  product, in_valid, clear, sum_ready,
    output in_ready, sum, sum_valid, overflow
  );

endinterface

// File: rtl/product_accumulator.sv
// Block accumulator for the multiply stage output: sums COUNT unsigned
// products into an ACC_WIDTH accumulator, then holds the block result with
// a sticky carry-out flag until the consumer takes it.
module product_accumulator #(
  parameter int WIDTH     = 16,
  parameter int COUNT     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  nReset,
  product_accumulator_if.slave  bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] sum_q;
  logic                 sum_valid_q;
  logic                 overflow_q;

  logic [ACC_WIDTH:0]   acc_add;
  logic                 carry;
  logic                 take;

  // Unsigned add of a zero-extended product; the extra MSB is the carry out.
  function automatic logic [ACC_WIDTH:0] add_carry(
    input logic [ACC_WIDTH-1:0] a,
    input logic [WIDTH-1:0]     p
  );
    logic [ACC_WIDTH:0] ext_a;
    logic [ACC_WIDTH:0] ext_p;
    ext_a = {1'b0, a};
    ext_p = {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, p};
    return ext_a + ext_p;
  endfunction

  // Ready depends only on state and reset, never on the input valid.
  assign bus.in_ready = (state == ACCUM) && !nReset;

  // A product is taken only when ready, valid and not being aborted.
  assign take = bus.in_ready && bus.in_valid && !bus.clear;

  // Next accumulator value and its carry out of ACC_WIDTH.
  always_comb begin
    acc_add = add_carry(acc, bus.product);
    carry   = acc_add[ACC_WIDTH];
  end

  // Block FSM: accumulate COUNT products, then hold the result for the consumer.
  always_ff @(posedge clk) begin
    if (nReset) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (take) begin
            if (cnt == LAST) begin
              sum_q       <= acc_add[ACC_WIDTH-1:0];
              overflow_q  <= ovf | carry;
              sum_valid_q <= 1'b1;
              acc         <= '0;
              cnt         <= '0;
              ovf         <= 1'b0;
              state       <= HOLD;
            end else begin
              acc <= acc_add[ACC_WIDTH-1:0];
              cnt <= cnt + 1'b1;
              ovf <= ovf | carry;
            end
          end
        end
        HOLD: begin
          if (bus.sum_ready) begin
            sum_valid_q <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. Two instances share one stimulus
// stream: a 20-bit accumulator and a 17-bit one (both COUNT=4), so the same
// products exercise both the no-wrap and the wrap/overflow behaviour.
module tb_product_accumulator;

  logic        clk;
  logic        nReset;
  logic [15:0] product;
  logic        in_valid;
  logic        clear;
  logic        sum_ready;

  int n_tests = 0;
  int n_fail  = 0;

  product_accumulator_if #(.WIDTH(16), .ACC_WIDTH(20)) bus_a ();
  product_accumulator_if #(.WIDTH(16), .ACC_WIDTH(17)) bus_b ();

  assign bus_a.product   = product;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.clear     = clear;
  assign bus_a.sum_ready = sum_ready;
  assign bus_b.product   = product;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.clear     = clear;
  assign bus_b.sum_ready = sum_ready;

  product_accumulator #(.WIDTH(16), .COUNT(4), .ACC_WIDTH(20)) u_a (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus_a)
  );

  product_accumulator #(.WIDTH(16), .COUNT(4), .ACC_WIDTH(17)) u_b (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs applied for a cycle, and the outputs expected to be
  // visible during that same cycle (before its closing edge).
  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] prod;
    logic        clr;
    logic        srdy;
    logic        e_ird;
    logic        e_svld;
    logic [19:0] e_sum_a;
    logic        e_ovf_a;
    logic [16:0] e_sum_b;
    logic        e_ovf_b;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vld, input logic [15:0] prod,
                     input logic clr, input logic srdy, input logic ird,
                     input logic svld, input logic [19:0] sa, input logic oa,
                     input logic [16:0] sb, input logic ob);
    vec_t v;
    v.rst = rst; v.vld = vld; v.prod = prod; v.clr = clr; v.srdy = srdy;
    v.e_ird = ird; v.e_svld = svld;
    v.e_sum_a = sa; v.e_ovf_a = oa; v.e_sum_b = sb; v.e_ovf_b = ob;
    vecs.push_back(v);
  endtask

  // Same expected result for both widths (no wrap involved).
  task automatic add_s(input logic rst, input logic vld, input logic [15:0] prod,
                       input logic clr, input logic srdy, input logic ird,
                       input logic svld, input logic [19:0] s, input logic o);
    add(rst, vld, prod, clr, srdy, ird, svld, s, o, s[16:0], o);
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [15:0] prod,
                       input logic clr, input logic srdy);
    nReset = rst; in_valid = vld; product = prod; clear = clr; sum_ready = srdy;
  endtask

  initial begin
    logic [22:0] got_a, exp_a;
    logic [19:0] got_b, exp_b;
    int          pulses;
    bit          found;

    drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Reset held with traffic offered
    repeat (5) add_s(1, 1, 16'h1234, 0, 1, 0, 0, 20'h0, 0);
    add_s(0, 0, 16'h0, 0, 1, 1, 0, 20'h0, 0);
    // Basic block
    add_s(0, 1, 16'h0025, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h004A, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h006F, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0094, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0777, 0, 1, 0, 1, 20'h00172, 0);
    add_s(0, 0, 16'h0000, 0, 1, 1, 0, 20'h00172, 0);
    // Backpressure
    for (int k = 1; k <= 4; k++) add_s(0, 1, 16'(k), 0, 0, 1, 0, 20'h00172, 0);
    repeat (10) add_s(0, 1, 16'hFFFF, 0, 0, 0, 1, 20'h0000A, 0);
    add_s(0, 0, 16'h0000, 0, 1, 0, 1, 20'h0000A, 0);
    add_s(0, 0, 16'h0000, 0, 0, 1, 0, 20'h0000A, 0);
    // Overflow on the 17-bit instance, sticky from the third add
    repeat (4) add_s(0, 1, 16'hFFFF, 0, 1, 1, 0, 20'h0000A, 0);
    add(0, 0, 16'h0000, 0, 1, 0, 1, 20'h3FFFC, 0, 17'h1FFFC, 1);
    repeat (4) add(0, 1, 16'h0000, 0, 1, 1, 0, 20'h3FFFC, 0, 17'h1FFFC, 1);
    add_s(0, 0, 16'h0000, 0, 1, 0, 1, 20'h0, 0);
    add_s(0, 0, 16'h0000, 0, 1, 1, 0, 20'h0, 0);
    // Clear discards the partial block and the product offered with it
    add_s(0, 1, 16'h0010, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0020, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0030, 1, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0001, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 0, 16'h0099, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0001, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0001, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 1, 16'h0001, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 0, 16'h0000, 1, 0, 0, 1, 20'h00004, 0);
    add_s(0, 1, 16'h0005, 1, 0, 0, 1, 20'h00004, 0);
    add_s(0, 0, 16'h0000, 0, 1, 0, 1, 20'h00004, 0);
    add_s(0, 0, 16'h0000, 0, 1, 1, 0, 20'h00004, 0);
    // Reset mid-block, then reset during HOLD
    repeat (3) add_s(0, 1, 16'h0007, 0, 1, 1, 0, 20'h00004, 0);
    add_s(1, 1, 16'h0007, 0, 1, 0, 0, 20'h00004, 0);
    repeat (4) add_s(0, 1, 16'h0002, 0, 1, 1, 0, 20'h0, 0);
    add_s(0, 0, 16'h0000, 0, 0, 0, 1, 20'h00008, 0);
    add_s(1, 0, 16'h0000, 0, 0, 0, 1, 20'h00008, 0);
    add_s(0, 0, 16'h0000, 0, 0, 1, 0, 20'h0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].prod, vecs[i].clr, vecs[i].srdy);
      @(negedge clk);
      got_a = {bus_a.in_ready, bus_a.sum_valid, bus_a.overflow, bus_a.sum};
      exp_a = {vecs[i].e_ird, vecs[i].e_svld, vecs[i].e_ovf_a, vecs[i].e_sum_a};
      got_b = {bus_b.in_ready, bus_b.sum_valid, bus_b.overflow, bus_b.sum};
      exp_b = {vecs[i].e_ird, vecs[i].e_svld, vecs[i].e_ovf_b, vecs[i].e_sum_b};
      n_tests++;
      if (got_a !== exp_a) begin
        n_fail++;
        $display("FAIL vec%0d acc20: got rdy=%b vld=%b ovf=%b sum=%h, expected rdy=%b vld=%b ovf=%b sum=%h",
                 i, got_a[22], got_a[21], got_a[20], got_a[19:0],
                 exp_a[22], exp_a[21], exp_a[20], exp_a[19:0]);
      end
      n_tests++;
      if (got_b !== exp_b) begin
        n_fail++;
        $display("FAIL vec%0d acc17: got rdy=%b vld=%b ovf=%b sum=%h, expected rdy=%b vld=%b ovf=%b sum=%h",
                 i, got_b[19], got_b[18], got_b[17], got_b[16:0],
                 exp_b[19], exp_b[18], exp_b[17], exp_b[16:0]);
      end
      @(posedge clk); #1;
    end

    // Throughput: continuous traffic gives one result every COUNT+1 cycles
    drive(1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus_a.sum_valid === 1'b1) begin
        pulses++;
        n_tests++;
        if (bus_a.sum !== 20'h4 || bus_a.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL throughput_result cycle%0d: got sum=%h rdy=%b, expected sum=00004 rdy=0",
                   c, bus_a.sum, bus_a.in_ready);
        end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL throughput_pulses: got %0d, expected 3", pulses);
    end

    // Gapped input, then a bounded wait for the result under backpressure
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, (c % 2) == 0, 16'h0100, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    found = 1'b0;
    for (int t = 0; t < 6 && !found; t++) begin
      @(negedge clk);
      if (bus_a.sum_valid === 1'b1) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL gap_wait: sum_valid not seen within 6 cycles, expected 1");
    end else begin
      n_tests++;
      if (bus_a.sum !== 20'h00400 || bus_b.sum !== 17'h00400) begin
        n_fail++;
        $display("FAIL gap_sum: got acc20=%h acc17=%h, expected 00400 both",
                 bus_a.sum, bus_b.sum);
      end
    end
    sum_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
